// File: rtl/i2c_slave.sv
// i2c_slave: memory-mapped I2C target. Oversamples SCL/SDA, matches a 7-bit address and
// either captures up to four written bytes into RDR or returns bytes from TDR.
module i2c_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        write_i,
  input  logic [3:0]  data_be_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  inout  wire         sda_io,
  input  logic        scl_i
);
  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StIgnore
  } state_e;

  state_e            state_q;
  logic [6:0]        sadr_q;
  logic [31:0]       rdr_q, tdr_q;
  logic              en_q, rx_done_q, tx_done_q, addr_hit_q, rw_q, sda_oe_q;
  logic [2:0]        rx_cnt_q, bit_cnt_q, tx_idx_q;
  logic [6:0]        shift_q;
  logic [Stages-1:0] scl_sync_q, sda_sync_q;
  logic              scl_prev_q, sda_prev_q;

  logic              scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;
  logic              clr_rx, clr_tx, rx_set, tx_set;
  logic [5:0]        lane_addr [4];
  logic [7:0]        tx_byte, stat, byte_v;

  assign sda_io = sda_oe_q ? 1'b0 : 1'bz;

  // Synchronisers idle high so reset release never looks like a bus event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[Stages-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[Stages-2:0], sda_io};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Bus event decode on synchronised lines.
  always_comb begin
    scl_s     = scl_sync_q[Stages-1];
    sda_s     = sda_sync_q[Stages-1];
    scl_rise  = scl_s & ~scl_prev_q;
    scl_fall  = ~scl_s & scl_prev_q;
    start_evt = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    stop_evt  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    rx_set    = en_q & stop_evt & addr_hit_q & ~rw_q & (rx_cnt_q != 3'd0);
    tx_set    = en_q & stop_evt & addr_hit_q & rw_q;
    tx_byte   = tx_idx_q[2] ? 8'hFF : tdr_q[{tx_idx_q[1:0], 3'b000} +: 8];
    stat      = {1'b0, addr_hit_q, tx_done_q, rx_done_q, state_q != StIdle, rx_cnt_q};
  end

  // Per-lane byte addresses and CFG write-1-to-clear pulses.
  always_comb begin
    clr_rx = 1'b0;
    clr_tx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = {1'b0, addr_i} + 6'(i);
      if (write_i && lane_addr[i] == 6'h10) begin
        clr_rx = clr_rx | wdata_i[8*i+1];
        clr_tx = clr_tx | wdata_i[8*i+2];
      end
    end
  end

  // Combinational register read, zero for disabled lanes and unmapped bytes.
  always_comb begin
    rdata_o = '0;
    byte_v  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      case (lane_addr[i])
        6'h00:                      byte_v = {1'b0, sadr_q};
        6'h04:                      byte_v = stat;
        6'h08, 6'h09, 6'h0A, 6'h0B: byte_v = rdr_q[{lane_addr[i][1:0], 3'b000} +: 8];
        6'h0C, 6'h0D, 6'h0E, 6'h0F: byte_v = tdr_q[{lane_addr[i][1:0], 3'b000} +: 8];
        6'h10:                      byte_v = {7'b0, en_q};
        default:                    byte_v = 8'h00;
      endcase
      if (data_be_i[i]) rdata_o[8*i +: 8] = byte_v;
    end
  end

  // CPU-writable registers and sticky flags; a flag set beats a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sadr_q    <= '0;
      tdr_q     <= '0;
      en_q      <= 1'b0;
      rx_done_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      if (write_i) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_addr[i] == 6'h00) sadr_q <= wdata_i[8*i +: 7];
          if (lane_addr[i] >= 6'h0C && lane_addr[i] <= 6'h0F) begin
            tdr_q[{lane_addr[i][1:0], 3'b000} +: 8] <= wdata_i[8*i +: 8];
          end
          if (lane_addr[i] == 6'h10) en_q <= wdata_i[8*i];
        end
      end
      rx_done_q <= rx_set | (rx_done_q & ~clr_rx);
      tx_done_q <= tx_set | (tx_done_q & ~clr_tx);
    end
  end

  // Protocol FSM; SDA drive changes only on SCL falling edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sda_oe_q   <= 1'b0;
      rdr_q      <= '0;
      rx_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      tx_idx_q   <= '0;
      shift_q    <= '0;
      addr_hit_q <= 1'b0;
      rw_q       <= 1'b0;
    end else if (!en_q) begin
      state_q    <= StIdle;
      sda_oe_q   <= 1'b0;
      addr_hit_q <= 1'b0;
    end else if (start_evt) begin
      state_q   <= StAddr;
      sda_oe_q  <= 1'b0;
      rx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      bit_cnt_q <= 3'd7;
    end else if (stop_evt) begin
      state_q    <= StIdle;
      sda_oe_q   <= 1'b0;
      addr_hit_q <= 1'b0;
    end else begin
      case (state_q)
        StAddr: if (scl_rise) begin
          shift_q   <= {shift_q[5:0], sda_s};
          bit_cnt_q <= bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            // shift_q holds the 7 address bits; sda_s is the R/W bit.
            if (shift_q == sadr_q) begin
              state_q    <= StAddrAck;
              addr_hit_q <= 1'b1;
              rw_q       <= sda_s;
            end else begin
              state_q <= StIgnore;
            end
          end
        end
        StAddrAck, StRxAck: if (scl_fall) begin
          // First fall starts the ACK drive, second fall ends it.
          if (!sda_oe_q) begin
            sda_oe_q <= 1'b1;
          end else if (state_q == StAddrAck && rw_q) begin
            state_q   <= StTx;
            shift_q   <= tx_byte[6:0];
            sda_oe_q  <= ~tx_byte[7];
            bit_cnt_q <= 3'd7;
          end else begin
            state_q   <= StRx;
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= 3'd7;
          end
        end
        StRx: if (scl_rise) begin
          shift_q   <= {shift_q[5:0], sda_s};
          bit_cnt_q <= bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            if (!rx_cnt_q[2]) begin
              rdr_q[{rx_cnt_q[1:0], 3'b000} +: 8] <= {shift_q, sda_s};
              rx_cnt_q <= rx_cnt_q + 3'd1;
              state_q  <= StRxAck;
            end else begin
              state_q <= StIgnore;
            end
          end
        end
        StTx: if (scl_fall) begin
          if (bit_cnt_q != 3'd0) begin
            sda_oe_q  <= ~shift_q[6];
            shift_q   <= {shift_q[5:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - 3'd1;
          end else begin
            sda_oe_q <= 1'b0;
            state_q  <= StTxAck;
          end
        end
        StTxAck: begin
          // Any fall seen here follows an ACKed byte, since NACK leaves the state.
          if (scl_rise) begin
            if (sda_s) state_q <= StIgnore;
            else if (!tx_idx_q[2]) tx_idx_q <= tx_idx_q + 3'd1;
          end else if (scl_fall) begin
            state_q   <= StTx;
            shift_q   <= tx_byte[6:0];
            sda_oe_q  <= ~tx_byte[7];
            bit_cnt_q <= 3'd7;
          end
        end
        StIdle, StIgnore: sda_oe_q <= 1'b0;
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master against a transaction-level model of the target.
`timescale 1ns/1ps
module tb_i2c_slave;
  localparam int SyncStages = 2;
  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic        clk = 1'b0, rst = 1'b1;
  logic        write_en = 1'b0;
  logic [3:0]  be = '0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        scl = 1'b1, m_low = 1'b0;
  wire         sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SYNC_STAGES(SyncStages)) dut (
    .clk_i(clk), .rst_i(rst), .write_i(write_en), .data_be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .sda_io(sda), .scl_i(scl)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0]  m_sadr = '0;
  logic [31:0] m_rdr = '0, m_tdr = '0;
  logic        m_en = 0, m_rx_done = 0, m_tx_done = 0, m_hit = 0, m_rw = 0;
  int          m_rxcnt = 0, m_k = 0;
  logic [7:0]  wbuf [8];

  function automatic logic [7:0] m_byte(input int a);
    if (a == 0) return {1'b0, m_sadr};
    if (a == 4) return {1'b0, m_hit, m_tx_done, m_rx_done, 1'b0, 3'(m_rxcnt)};
    if (a >= 8 && a <= 11) return m_rdr[8*(a-8) +: 8];
    if (a >= 12 && a <= 15) return m_tdr[8*(a-12) +: 8];
    if (a == 16) return {7'b0, m_en};
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [3:0] b);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = m_byte(int'(a) + i);
    return r;
  endfunction

  function automatic void m_reset();
    m_sadr = '0; m_rdr = '0; m_tdr = '0; m_en = 0; m_rx_done = 0; m_tx_done = 0;
    m_hit = 0; m_rw = 0; m_rxcnt = 0; m_k = 0;
  endfunction

  function automatic logic m_addr(input logic [7:0] b);
    if (m_en && b[7:1] == m_sadr) begin
      m_hit = 1; m_rw = b[0];
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic m_wr_byte(input logic [7:0] b);
    if (m_rxcnt < 4) begin
      m_rdr[8*m_rxcnt +: 8] = b;
      m_rxcnt++;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void m_stop();
    if (m_hit) begin
      if (!m_rw && m_rxcnt > 0) m_rx_done = 1;
      if (m_rw) m_tx_done = 1;
      m_hit = 0;
    end
  endfunction

  // ---------------- CPU bus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); write_en = 1; addr = a; wdata = d; be = 4'hF;
    @(negedge clk); write_en = 0;
    for (int i = 0; i < 4; i++) begin
      int la = int'(a) + i;
      logic [7:0] v = d[8*i +: 8];
      if (la == 0) m_sadr = v[6:0];
      if (la >= 12 && la <= 15) m_tdr[8*(la-12) +: 8] = v;
      if (la == 16) begin
        m_en = v[0];
        if (v[1]) m_rx_done = 0;
        if (v[2]) m_tx_done = 0;
      end
    end
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [3:0] b);
    @(negedge clk); addr = a; be = b;
    #1 check_eq(tag, rdata, m_read(a, b));
  endtask

  // ---------------- I2C master ----------------
  task automatic bit_cycle(input logic b, output logic s);
    m_low = ~b; wait_cyc(Q);
    scl = 1;    wait_cyc(Q);
    s = sda;    wait_cyc(Q);
    scl = 0;    wait_cyc(Q);
  endtask

  task automatic bus_start();
    m_low = 0; wait_cyc(Q);
    scl = 1;   wait_cyc(Q);
    m_low = 1; wait_cyc(Q);
    scl = 0;   wait_cyc(Q);
  endtask

  task automatic bus_stop();
    m_low = 1; wait_cyc(Q);
    scl = 1;   wait_cyc(Q);
    m_low = 0; wait_cyc(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  // START (or repeated START), address, then n data bytes from wbuf or read back.
  task automatic xfer(input logic [6:0] a, input logic rd, input int n, input string tag);
    logic ack, exp_ack;
    logic [7:0] d, exp_d;
    bus_start();
    m_rxcnt = 0; m_k = 0;
    exp_ack = m_addr({a, rd});
    wr_byte({a, rd}, ack);
    check_eq({tag, " addr_ack"}, ack, exp_ack);
    if (!exp_ack) begin
      for (int i = 0; i < n; i++) begin
        if (!rd) begin
          exp_ack = m_wr_byte(wbuf[i]);
          wr_byte(wbuf[i], ack);
          check_eq({tag, " data_ack"}, ack, exp_ack);
          if (exp_ack) break;
        end else begin
          exp_d = (m_k < 4) ? m_tdr[8*m_k +: 8] : 8'hFF;
          rd_byte(i == n - 1, d);
          check_eq({tag, " rd_data"}, d, exp_d);
          if (i != n - 1) m_k++;
        end
      end
    end
  endtask

  initial begin
    logic s, ack;
    // Reset values
    wait_cyc(3);
    check_eq("rst sda", {31'b0, sda}, 32'h1);
    rst = 0;
    rd_check("rst sadr", 5'h00, 4'hF);
    rd_check("rst stat", 5'h04, 4'hF);
    rd_check("rst rdr", 5'h08, 4'hF);
    rd_check("rst tdr", 5'h0C, 4'hF);
    rd_check("rst cfg", 5'h10, 4'hF);

    // Reset while the target drives the address ACK
    cpu_wr(5'h00, 32'h42);
    cpu_wr(5'h10, 32'h1);
    bus_start();
    for (int i = 7; i >= 0; i--) bit_cycle(1'(8'h84 >> i), s);
    m_low = 0; wait_cyc(Q);
    scl = 1;   wait_cyc(Q);
    check_eq("ack low", {31'b0, sda}, 32'h0);
    rst = 1;
    #1 check_eq("rst release sda", {31'b0, sda}, 32'h1);
    m_reset();
    scl = 0;
    wait_cyc(3);
    rst = 0;
    rd_check("stat after rst", 5'h04, 4'hF);
    rd_check("cfg after rst", 5'h10, 4'h1);
    bus_stop();

    // Write two bytes
    cpu_wr(5'h00, 32'h42);
    cpu_wr(5'h10, 32'h1);
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    xfer(7'h42, 1'b0, 2, "wr2");
    bus_stop(); m_stop();
    rd_check("wr2 rdr", 5'h08, 4'hF);
    check_eq("wr2 rdr const", m_rdr, 32'h00003CA5);
    rd_check("wr2 stat", 5'h04, 4'h1);

    // Read five bytes, last one NACKed
    cpu_wr(5'h0C, 32'h44332211);
    xfer(7'h42, 1'b1, 5, "rd5");
    bus_stop(); m_stop();
    rd_check("rd5 stat", 5'h04, 4'h1);

    // Address mismatch
    cpu_wr(5'h10, 32'h7);
    xfer(7'h50, 1'b0, 1, "miss");
    bus_stop(); m_stop();
    rd_check("miss stat", 5'h04, 4'h1);

    // Overflow then repeated START read
    for (int i = 0; i < 5; i++) wbuf[i] = 8'(i + 1);
    xfer(7'h42, 1'b0, 5, "ovf");
    check_eq("ovf rdr const", m_rdr, 32'h04030201);
    xfer(7'h42, 1'b1, 1, "rs");
    bus_stop(); m_stop();
    rd_check("ovf rdr", 5'h08, 4'hF);
    rd_check("ovf stat", 5'h04, 4'hF);

    // CFG clear in the same cycle the STOP sets rx_done
    cpu_wr(5'h10, 32'h7);
    wbuf[0] = 8'h5A;
    xfer(7'h42, 1'b0, 1, "race");
    m_low = 1; wait_cyc(Q);
    scl = 1;   wait_cyc(Q);
    m_low = 0;
    wait_cyc(SyncStages);
    write_en = 1; addr = 5'h10; wdata = 32'h3; be = 4'hF;
    @(negedge clk); write_en = 0;
    m_rx_done = 0; m_stop();
    wait_cyc(Q);
    rd_check("race stat", 5'h04, 4'h1);
    cpu_wr(5'h10, 32'h3);
    rd_check("race clr stat", 5'h04, 4'h1);
    rd_check("race cfg", 5'h10, 4'h1);

    // Randomized transactions
    for (int r = 0; r < 8; r++) begin
      logic [6:0] sa, ta;
      logic rdir;
      int n;
      sa = 7'($urandom);
      cpu_wr(5'h00, {25'b0, sa});
      cpu_wr(5'h0C, $urandom);
      ta = ($urandom_range(0, 3) != 0) ? sa : 7'($urandom);
      rdir = 1'($urandom);
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      xfer(ta, rdir, n, "rnd");
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        xfer(sa, ~rdir, $urandom_range(1, 5), "rnd_rs");
      end
      bus_stop(); m_stop();
      rd_check("rnd stat", 5'h04, 4'hF);
      rd_check("rnd rdr", 5'h08, 4'hF);
      rd_check("rnd reg", 5'($urandom_range(0, 19)), 4'($urandom));
      if (r % 3 == 2) cpu_wr(5'h10, 32'h7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
